u712_chip_cycle_sequencer: RTL and testbench

- Upstream neighbour of the byte-enable stage in U712.
- Accepts 68040 transfer starts that decode to the 16-bit Amiga chipset region.
- Splits each 32-bit request into one or two 16-bit chipset cycles and drives the per-cycle address, size and strobe window consumed by the byte-enable logic.
- Collects chipset acknowledges and terminates the CPU cycle with TA, TEA or TBI.

---
 rtl/u712_chip_cycle_sequencer.sv | 153 +++++++++++++++
 tb/tb_u712_chip_cycle_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/u712_chip_cycle_sequencer.sv
// rtl/u712_chip_cycle_sequencer.sv - 68040 to 16-bit chipset cycle splitter/terminator
// Splits each CPU transfer into one or two chipset word cycles and returns TA/TEA/TBI.
module u712_chip_cycle_sequencer #(
  parameter int SETUP_CLKS  = 1,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       CLK40,
  input  logic       RESETn,
  input  logic       TSn,
  input  logic       CHIP_SEL,
  input  logic       RnW,
  input  logic [1:0] A_IN,
  input  logic [1:0] SIZ_IN,
  input  logic       CHIP_ACKn,
  output logic       CHIP_CYCLE,
  output logic [1:0] A_OUT,
  output logic [1:0] SIZ_OUT,
  output logic       RnW_OUT,
  output logic       DS_EN,
  output logic       WORD_SEL,
  output logic       RD_LATCH,
  output logic       TAn,
  output logic       TEAn,
  output logic       TBIn
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_RECOVER, S_TERM, S_ERROR
  } state_t;

  localparam logic [2:0] SETUP_LAST = 3'(SETUP_CLKS - 1);
  localparam logic [7:0] TO_LAST    = 8'(ACK_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [1:0] a_q, a_d;
  logic [1:0] siz_q, siz_d;
  logic [1:0] siz_lat_q, siz_lat_d;
  logic       rnw_q, rnw_d;
  logic       ws_q, ws_d;
  logic       second_q, second_d;
  logic [2:0] setup_cnt_q, setup_cnt_d;
  logic [7:0] to_cnt_q, to_cnt_d;

  always_ff @(posedge CLK40 or negedge RESETn) begin
    if (!RESETn) begin
      state_q     <= S_IDLE;
      a_q         <= 2'b00;
      siz_q       <= 2'b00;
      siz_lat_q   <= 2'b00;
      rnw_q       <= 1'b1;
      ws_q        <= 1'b0;
      second_q    <= 1'b0;
      setup_cnt_q <= 3'd0;
      to_cnt_q    <= 8'd0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      siz_q       <= siz_d;
      siz_lat_q   <= siz_lat_d;
      rnw_q       <= rnw_d;
      ws_q        <= ws_d;
      second_q    <= second_d;
      setup_cnt_q <= setup_cnt_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    siz_d       = siz_q;
    siz_lat_d   = siz_lat_q;
    rnw_d       = rnw_q;
    ws_d        = ws_q;
    second_d    = second_q;
    setup_cnt_d = setup_cnt_q;
    to_cnt_d    = to_cnt_q;
    CHIP_CYCLE  = 1'b0;
    DS_EN       = 1'b0;
    RD_LATCH    = 1'b0;
    TAn         = 1'b1;
    TEAn        = 1'b1;
    TBIn        = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (!TSn && CHIP_SEL) begin
          rnw_d       = RnW;
          siz_lat_d   = SIZ_IN;
          setup_cnt_d = 3'd0;
          to_cnt_d    = 8'd0;
          state_d     = S_SETUP;
          case (SIZ_IN)
            2'b01: begin a_d = A_IN;  siz_d = 2'b01; ws_d = A_IN[1]; second_d = 1'b0; end
            2'b10: begin a_d = A_IN;  siz_d = 2'b10; ws_d = A_IN[1]; second_d = 1'b0; end
            // Long and line both become upper word then lower word.
            default: begin a_d = 2'b00; siz_d = 2'b10; ws_d = 1'b0; second_d = 1'b1; end
          endcase
        end
      end
      S_SETUP: begin
        CHIP_CYCLE = 1'b1;
        if (setup_cnt_q == SETUP_LAST) begin
          setup_cnt_d = 3'd0;
          state_d     = S_STROBE;
        end else begin
          setup_cnt_d = setup_cnt_q + 3'd1;
        end
      end
      S_STROBE: begin
        CHIP_CYCLE = 1'b1;
        DS_EN      = 1'b1;
        to_cnt_d   = to_cnt_q + 8'd1;
        // Acknowledge is tested first so it wins on the timeout clock.
        if (!CHIP_ACKn)              state_d = S_RECOVER;
        else if (to_cnt_q == TO_LAST) state_d = S_ERROR;
      end
      S_RECOVER: begin
        CHIP_CYCLE = 1'b1;
        RD_LATCH   = rnw_q;
        to_cnt_d   = 8'd0;
        if (second_q) begin
          a_d      = 2'b10;
          ws_d     = 1'b1;
          second_d = 1'b0;
          state_d  = S_SETUP;
        end else begin
          state_d  = S_TERM;
        end
      end
      S_TERM: begin
        CHIP_CYCLE = 1'b1;
        TAn        = 1'b0;
        TBIn       = (siz_lat_q != 2'b11);
        state_d    = S_IDLE;
      end
      S_ERROR: begin
        CHIP_CYCLE = 1'b1;
        TEAn       = 1'b0;
        second_d   = 1'b0;
        to_cnt_d   = 8'd0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign A_OUT    = a_q;
  assign SIZ_OUT  = siz_q;
  assign RnW_OUT  = rnw_q;
  assign WORD_SEL = ws_q;

endmodule

// File: tb/tb_u712_chip_cycle_sequencer.sv
// tb/tb_u712_chip_cycle_sequencer.sv - directed bench for the chipset cycle sequencer
module tb_u712_chip_cycle_sequencer;

  logic       CLK40 = 1'b0;
  logic       RESETn = 1'b0;
  logic       TSn = 1'b1, CHIP_SEL = 1'b0, RnW = 1'b1, CHIP_ACKn = 1'b1;
  logic [1:0] A_IN = 2'b00, SIZ_IN = 2'b00;
  logic       CHIP_CYCLE, RnW_OUT, DS_EN, WORD_SEL, RD_LATCH, TAn, TEAn, TBIn;
  logic [1:0] A_OUT, SIZ_OUT;

  int n_checks = 0;
  int n_fail   = 0;

  u712_chip_cycle_sequencer #(.SETUP_CLKS(1), .ACK_TIMEOUT(4)) dut (
    .CLK40(CLK40), .RESETn(RESETn), .TSn(TSn), .CHIP_SEL(CHIP_SEL), .RnW(RnW),
    .A_IN(A_IN), .SIZ_IN(SIZ_IN), .CHIP_ACKn(CHIP_ACKn), .CHIP_CYCLE(CHIP_CYCLE),
    .A_OUT(A_OUT), .SIZ_OUT(SIZ_OUT), .RnW_OUT(RnW_OUT), .DS_EN(DS_EN),
    .WORD_SEL(WORD_SEL), .RD_LATCH(RD_LATCH), .TAn(TAn), .TEAn(TEAn), .TBIn(TBIn)
  );

  always #5 CLK40 = ~CLK40;

  // Mid-clock observer: strobe windows, read-latch pulses and terminations.
  int         clr_req = 0, clr_seen = 0;
  int         n_win, n_rd, n_ta, n_tea, n_tbi, n_overlap, n_ds_change;
  int         win_len [8];
  logic [1:0] win_a [8], win_siz [8];
  logic       win_ws [8], rd_ws [8];
  logic       prev_ds = 1'b0;
  logic [1:0] prev_a = 2'b00, prev_siz = 2'b00;

  always @(negedge CLK40) begin
    if (clr_req != clr_seen) begin
      clr_seen = clr_req;
      n_win = 0; n_rd = 0; n_ta = 0; n_tea = 0; n_tbi = 0; n_overlap = 0; n_ds_change = 0;
      for (int i = 0; i < 8; i++) win_len[i] = 0;
    end
    if (!RESETn) begin
      prev_ds = 1'b0;
    end else begin
      if (DS_EN && !prev_ds && n_win < 8) begin
        win_a[n_win] = A_OUT; win_siz[n_win] = SIZ_OUT; win_ws[n_win] = WORD_SEL;
        n_win++;
      end
      if (DS_EN && n_win > 0) win_len[n_win-1]++;
      if (DS_EN && prev_ds && (A_OUT != prev_a || SIZ_OUT != prev_siz)) n_ds_change++;
      if (RD_LATCH && n_rd < 8) begin rd_ws[n_rd] = WORD_SEL; n_rd++; end
      if (!TAn) n_ta++;
      if (!TEAn) n_tea++;
      if (!TBIn) n_tbi++;
      if (!TAn && !TEAn) n_overlap++;
      prev_ds = DS_EN; prev_a = A_OUT; prev_siz = SIZ_OUT;
    end
  end

  task automatic tick();
    @(posedge CLK40);
    #1;
  endtask

  // Presents a chipset transfer start; returns during clock 1 (TSn edge is edge 0).
  task automatic start(input logic rnw, input logic [1:0] a, input logic [1:0] siz);
    clr_req++;
    RnW = rnw; A_IN = a; SIZ_IN = siz; CHIP_SEL = 1'b1; TSn = 1'b0;
    tick();
    TSn = 1'b1; CHIP_SEL = 1'b0;
  endtask

  // Acts as the chipset: acknowledges ack_delay clocks into each strobe window.
  task automatic run_xfer(input bit ack_en, input int ack_delay,
                          output int ta_at, output int tea_at, output int tbi_at, output int end_at);
    int c = 1;
    int k = 0;
    bit done = 0;
    ta_at = -1; tea_at = -1; tbi_at = -1; end_at = -1;
    while (!done && c < 80) begin
      if (!TAn)  ta_at  = c;
      if (!TEAn) tea_at = c;
      if (!TBIn) tbi_at = c;
      if (!CHIP_CYCLE) begin
        end_at = c; done = 1;
      end else begin
        if (DS_EN) begin
          k++;
          CHIP_ACKn = (ack_en && k == ack_delay + 1) ? 1'b0 : 1'b1;
        end else begin
          k = 0; CHIP_ACKn = 1'b1;
        end
        tick();
        c++;
      end
    end
    CHIP_ACKn = 1'b1;
  endtask

  task automatic test_reset();
    RESETn = 1'b0;
    repeat (2) tick();
    n_checks++;
    if ({CHIP_CYCLE, A_OUT, SIZ_OUT, RnW_OUT, DS_EN, WORD_SEL, RD_LATCH, TAn, TEAn, TBIn} !== 12'b0_00_00_1_0_0_0_1_1_1) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected %b",
        {CHIP_CYCLE, A_OUT, SIZ_OUT, RnW_OUT, DS_EN, WORD_SEL, RD_LATCH, TAn, TEAn, TBIn}, 12'b0_00_00_1_0_0_0_1_1_1);
    end
    RESETn = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_byte_read();
    int ta, tea, tbi, fin;
    start(1'b1, 2'b11, 2'b01);
    n_checks++; if ({CHIP_CYCLE, DS_EN, A_OUT, SIZ_OUT, WORD_SEL, RnW_OUT} !== 8'b1_0_11_01_1_1) begin
      n_fail++; $display("FAIL byte_setup: got %b expected %b", {CHIP_CYCLE, DS_EN, A_OUT, SIZ_OUT, WORD_SEL, RnW_OUT}, 8'b1_0_11_01_1_1); end
    run_xfer(1'b1, 0, ta, tea, tbi, fin);
    n_checks++; if (ta !== 4) begin n_fail++; $display("FAIL byte_ta_clock: got %0d expected 4", ta); end
    n_checks++; if (fin !== 5) begin n_fail++; $display("FAIL byte_idle_clock: got %0d expected 5", fin); end
    n_checks++; if (tbi !== -1 || tea !== -1) begin n_fail++; $display("FAIL byte_tbi_tea: got tbi %0d tea %0d expected -1 -1", tbi, tea); end
    n_checks++; if (n_rd !== 1 || rd_ws[0] !== 1'b1) begin n_fail++; $display("FAIL byte_rd_latch: got %0d pulses ws %b expected 1 ws 1", n_rd, rd_ws[0]); end
    n_checks++; if (n_win !== 1 || win_len[0] !== 1 || win_a[0] !== 2'b11 || win_siz[0] !== 2'b01) begin
      n_fail++; $display("FAIL byte_window: got %0d win len %0d a %b siz %b expected 1 1 11 01", n_win, win_len[0], win_a[0], win_siz[0]); end
    n_checks++; if (n_ta !== 1) begin n_fail++; $display("FAIL byte_ta_count: got %0d expected 1", n_ta); end
  endtask

  task automatic test_long_write();
    int ta, tea, tbi, fin;
    start(1'b0, 2'b00, 2'b00);
    n_checks++; if ({A_OUT, SIZ_OUT, WORD_SEL, RnW_OUT} !== 6'b00_10_0_0) begin
      n_fail++; $display("FAIL long_setup: got %b expected %b", {A_OUT, SIZ_OUT, WORD_SEL, RnW_OUT}, 6'b00_10_0_0); end
    run_xfer(1'b1, 3, ta, tea, tbi, fin);
    n_checks++; if (ta !== 13 || fin !== 14) begin n_fail++; $display("FAIL long_ta_clock: got ta %0d idle %0d expected 13 14", ta, fin); end
    n_checks++; if (n_win !== 2 || win_len[0] !== 4 || win_len[1] !== 4) begin
      n_fail++; $display("FAIL long_windows: got %0d windows len %0d %0d expected 2 4 4", n_win, win_len[0], win_len[1]); end
    n_checks++; if ({win_a[0], win_siz[0], win_ws[0], win_a[1], win_siz[1], win_ws[1]} !== 10'b00_10_0_10_10_1) begin
      n_fail++; $display("FAIL long_word_map: got %b expected %b", {win_a[0], win_siz[0], win_ws[0], win_a[1], win_siz[1], win_ws[1]}, 10'b00_10_0_10_10_1); end
    n_checks++; if (n_rd !== 0 || n_ta !== 1 || n_tea !== 0 || tbi !== -1) begin
      n_fail++; $display("FAIL long_terms: got rd %0d ta %0d tea %0d tbi %0d expected 0 1 0 -1", n_rd, n_ta, n_tea, tbi); end
    n_checks++; if (n_ds_change !== 0 || n_overlap !== 0) begin
      n_fail++; $display("FAIL long_invariants: got change %0d overlap %0d expected 0 0", n_ds_change, n_overlap); end
  endtask

  task automatic test_line_read();
    int ta, tea, tbi, fin;
    start(1'b1, 2'b00, 2'b11);
    run_xfer(1'b1, 0, ta, tea, tbi, fin);
    n_checks++; if (ta !== 7 || tbi !== 7) begin n_fail++; $display("FAIL line_ta_tbi: got ta %0d tbi %0d expected 7 7", ta, tbi); end
    n_checks++; if (n_ta !== 1 || n_tbi !== 1) begin n_fail++; $display("FAIL line_pulse_count: got ta %0d tbi %0d expected 1 1", n_ta, n_tbi); end
    n_checks++; if (n_rd !== 2 || rd_ws[0] !== 1'b0 || rd_ws[1] !== 1'b1) begin
      n_fail++; $display("FAIL line_rd_latch: got %0d pulses ws %b%b expected 2 ws 01", n_rd, rd_ws[0], rd_ws[1]); end
  endtask

  task automatic test_timeout();
    int ta, tea, tbi, fin;
    start(1'b1, 2'b00, 2'b00);
    run_xfer(1'b0, 0, ta, tea, tbi, fin);
    n_checks++; if (tea !== 6 || ta !== -1) begin n_fail++; $display("FAIL timeout_tea_clock: got tea %0d ta %0d expected 6 -1", tea, ta); end
    n_checks++; if (fin === -1) begin n_fail++; $display("FAIL timeout_idle: got no return to idle expected idle"); end
    n_checks++; if (n_win !== 1 || win_len[0] !== 4) begin n_fail++; $display("FAIL timeout_window: got %0d windows len %0d expected 1 4", n_win, win_len[0]); end
    n_checks++; if (n_tea !== 1 || n_ta !== 0 || n_rd !== 0 || n_overlap !== 0) begin
      n_fail++; $display("FAIL timeout_terms: got tea %0d ta %0d rd %0d overlap %0d expected 1 0 0 0", n_tea, n_ta, n_rd, n_overlap); end
  endtask

  task automatic test_reset_mid_op();
    int ta, tea, tbi, fin;
    start(1'b1, 2'b00, 2'b00);
    tick(); CHIP_ACKn = 1'b0;
    tick(); CHIP_ACKn = 1'b1;
    tick(); tick();
    n_checks++; if ({DS_EN, WORD_SEL, A_OUT} !== 4'b1_1_10) begin
      n_fail++; $display("FAIL midreset_second_strobe: got %b expected %b", {DS_EN, WORD_SEL, A_OUT}, 4'b1_1_10); end
    RESETn = 1'b0;
    #1;
    n_checks++;
    if ({CHIP_CYCLE, A_OUT, SIZ_OUT, RnW_OUT, DS_EN, WORD_SEL, RD_LATCH, TAn, TEAn, TBIn} !== 12'b0_00_00_1_0_0_0_1_1_1) begin
      n_fail++; $display("FAIL midreset_outputs: got %b expected %b",
        {CHIP_CYCLE, A_OUT, SIZ_OUT, RnW_OUT, DS_EN, WORD_SEL, RD_LATCH, TAn, TEAn, TBIn}, 12'b0_00_00_1_0_0_0_1_1_1);
    end
    tick(); RESETn = 1'b1; tick();
    start(1'b1, 2'b00, 2'b00);
    n_checks++; if ({A_OUT, SIZ_OUT, WORD_SEL} !== 5'b00_10_0) begin
      n_fail++; $display("FAIL midreset_fresh_word: got %b expected %b", {A_OUT, SIZ_OUT, WORD_SEL}, 5'b00_10_0); end
    run_xfer(1'b1, 0, ta, tea, tbi, fin);
    n_checks++; if (ta !== 7 || n_rd !== 2) begin n_fail++; $display("FAIL midreset_rerun: got ta %0d rd %0d expected 7 2", ta, n_rd); end
  endtask

  task automatic test_ignored_inputs();
    int ta, tea, tbi, fin;
    start(1'b1, 2'b10, 2'b10);
    CHIP_ACKn = 1'b0;
    tick();
    CHIP_ACKn = 1'b1;
    n_checks++; if ({DS_EN, RD_LATCH} !== 2'b10) begin n_fail++; $display("FAIL stale_ack_setup: got %b expected 10", {DS_EN, RD_LATCH}); end
    TSn = 1'b0; CHIP_SEL = 1'b1; A_IN = 2'b01; SIZ_IN = 2'b01;
    tick();
    TSn = 1'b1; CHIP_SEL = 1'b0;
    n_checks++; if ({DS_EN, A_OUT, SIZ_OUT, WORD_SEL} !== 6'b1_10_10_1) begin
      n_fail++; $display("FAIL ts_in_strobe: got %b expected %b", {DS_EN, A_OUT, SIZ_OUT, WORD_SEL}, 6'b1_10_10_1); end
    run_xfer(1'b1, 0, ta, tea, tbi, fin);
    n_checks++; if (ta !== 3 || fin !== 4 || win_len[0] !== 2 || n_rd !== 1) begin
      n_fail++; $display("FAIL ts_in_strobe_term: got ta %0d idle %0d len %0d rd %0d expected 3 4 2 1", ta, fin, win_len[0], n_rd); end
    tick();
    n_checks++; if (CHIP_CYCLE !== 1'b0) begin n_fail++; $display("FAIL ts_in_strobe_no_queue: got %b expected 0", CHIP_CYCLE); end
    TSn = 1'b0; CHIP_SEL = 1'b0; SIZ_IN = 2'b00;
    tick();
    TSn = 1'b1;
    n_checks++; if (CHIP_CYCLE !== 1'b0) begin n_fail++; $display("FAIL unselected_ts: got %b expected 0", CHIP_CYCLE); end
    tick();
    n_checks++; if ({CHIP_CYCLE, DS_EN} !== 2'b00) begin n_fail++; $display("FAIL unselected_ts_later: got %b expected 00", {CHIP_CYCLE, DS_EN}); end
  endtask

  initial begin
    #1;
    test_reset();
    test_byte_read();
    test_long_write();
    test_line_read();
    test_timeout();
    test_reset_mid_op();
    test_ignored_inputs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected completion within 200000 time units");
    $fatal(1);
  end

endmodule
